// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared vectors, NOP word and fetch FSM encoding
package fetch_unit_pkg;
  localparam logic [31:0] RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] IRQ_VEC   = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC   = 32'h8000_0008;
  localparam logic [31:0] NOP       = 32'h0000_0000;
  typedef enum logic [1:0] {FETCH = 2'd0, DISCARD = 2'd1, HOLD = 2'd2} state_t;
endpackage

// File: rtl/fetch_unit_next_pc_sel.sv
// next_pc_sel: prioritised redirect target selection and sequential PC
module next_pc_sel
  import fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        exc,
  input  logic        irq,
  input  logic        jr,
  input  logic        j,
  input  logic        z,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  output logic        redirect,
  output logic [31:0] target,
  output logic [31:0] seq_pc
);
  logic        irq_ok;
  logic [31:0] raw;
  always_comb begin
    irq_ok   = irq & ~pc[31];
    redirect = exc | irq_ok | jr | j | z;
    raw      = exc ? EXC_VEC : irq_ok ? IRQ_VEC : jr ? jr_target : j ? jump_target : branch_target;
    target   = raw & ~32'h3;
    seq_pc   = pc + 32'd4;
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch with stall buffer and dead-path response discard
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        PC_IF_ID_Write,
  input  logic        Z,
  input  logic        J,
  input  logic        JR,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  input  logic        exc,
  input  logic        irq,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [63:0] IF_ID
);
  state_t      state, state_nx;
  logic [31:0] pc, word_buf, dead_addr, target, seq_pc;
  logic        redirect_raw, redirect;
  next_pc_sel u_sel (
    .pc(pc), .exc(exc), .irq(irq), .jr(JR), .j(J), .z(Z),
    .branch_target(branch_target), .jump_target(jump_target), .jr_target(jr_target),
    .redirect(redirect_raw), .target(target), .seq_pc(seq_pc)
  );
  assign redirect = PC_IF_ID_Write & redirect_raw;
  always_ff @(posedge clk)
    if (rst) state <= FETCH;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == FETCH)
      state_nx = redirect ? (imem_ack ? FETCH : DISCARD) : (!PC_IF_ID_Write && imem_ack) ? HOLD : FETCH;
    else if (state == HOLD)
      state_nx = PC_IF_ID_Write ? FETCH : HOLD;
    else
      state_nx = imem_ack ? FETCH : DISCARD;
  end
  // a dead request keeps its original address on the bus until acked
  always_comb begin
    imem_req  = !rst && state != HOLD;
    imem_addr = rst ? RESET_VEC : state == DISCARD ? dead_addr : pc;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_VEC;
      IF_ID     <= 64'h0;
      word_buf  <= NOP;
      dead_addr <= RESET_VEC;
    end else if (redirect) begin
      pc    <= target;
      IF_ID <= {target, NOP};
      if (state == FETCH) dead_addr <= pc;
    end else if (PC_IF_ID_Write) begin
      if (state == HOLD || (state == FETCH && imem_ack)) begin
        pc    <= seq_pc;
        IF_ID <= {seq_pc, state == HOLD ? word_buf : imem_rdata};
      end else IF_ID <= {pc, NOP};
    end else if (state == FETCH && imem_ack) word_buf <= imem_rdata;
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed per-cycle vectors checked by a scoreboard monitor
module tb_fetch_unit;
  logic        clk = 0, rst = 1, PC_IF_ID_Write = 0, Z = 0, J = 0, JR = 0, exc = 0, irq = 0;
  logic [31:0] branch_target = 32'h8000_0040, jump_target = 32'h0000_0100, jr_target = 32'h0000_0203;
  logic        imem_req, imem_ack = 0;
  logic [31:0] imem_addr, imem_rdata = 0;
  logic [63:0] IF_ID;
  localparam logic [4:0] R0 = 5'b00000, RZ = 5'b00001, RJ = 5'b00010, RJR = 5'b00100, RIRQ = 5'b01000, REXC = 5'b10000;
  typedef struct { string n; logic req; logic [31:0] addr; logic [63:0] ifid; } exp_t;
  exp_t q[$];
  exp_t e;
  int vec = 0, miss = 0;
  fetch_unit dut (
    .clk(clk), .rst(rst), .PC_IF_ID_Write(PC_IF_ID_Write), .Z(Z), .J(J), .JR(JR),
    .branch_target(branch_target), .jump_target(jump_target), .jr_target(jr_target),
    .exc(exc), .irq(irq), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .IF_ID(IF_ID)
  );
  always #5 clk = ~clk;
  // row: inputs for this cycle, and the outputs expected during this cycle
  task automatic c(input string n, input bit r, input bit w, input bit a, input logic [31:0] rd,
                   input logic [4:0] rv, input logic er, input logic [31:0] ea, input logic [63:0] ei);
    @(posedge clk); #1;
    rst = r; PC_IF_ID_Write = w; imem_ack = a; imem_rdata = rd;
    {exc, irq, JR, J, Z} = rv;
    q.push_back('{n, er, ea, ei});
  endtask
  initial forever begin
    @(negedge clk);
    if (q.size() > 0) begin
      e = q.pop_front();
      vec++;
      if (imem_req !== e.req || imem_addr !== e.addr || IF_ID !== e.ifid) begin
        miss++;
        $display("FAIL %s: got req=%0b addr=%h if_id=%h, want req=%0b addr=%h if_id=%h",
                 e.n, imem_req, imem_addr, IF_ID, e.req, e.addr, e.ifid);
      end
    end
  end
  initial begin
    c("rst_ack_ignored", 1, 1, 1, 32'h1111_1111, R0, 0, 32'h8000_0000, 64'h0);
    c("rst_release",     0, 1, 1, 32'h2008_0005, R0, 1, 32'h8000_0000, 64'h0);
    c("first_word",      0, 1, 0, 32'h0,         R0, 1, 32'h8000_0004, {32'h8000_0004, 32'h2008_0005});
    c("delay_a",         0, 1, 0, 32'h0,         R0, 1, 32'h8000_0004, {32'h8000_0004, 32'h0});
    c("delay_b",         0, 1, 0, 32'h0,         R0, 1, 32'h8000_0004, {32'h8000_0004, 32'h0});
    c("delay_c",         0, 1, 1, 32'h1234_5678, R0, 1, 32'h8000_0004, {32'h8000_0004, 32'h0});
    c("delayed_word",    0, 0, 1, 32'hCAFE_0001, R0, 1, 32'h8000_0008, {32'h8000_0008, 32'h1234_5678});
    c("hold_a",          0, 0, 0, 32'h0,         R0, 0, 32'h8000_0008, {32'h8000_0008, 32'h1234_5678});
    c("hold_b",          0, 1, 0, 32'h0,         R0, 0, 32'h8000_0008, {32'h8000_0008, 32'h1234_5678});
    c("buffered_out",    0, 1, 0, 32'h0,         RZ, 1, 32'h8000_000C, {32'h8000_000C, 32'hCAFE_0001});
    c("discard_a",       0, 1, 0, 32'h0,         R0, 1, 32'h8000_000C, {32'h8000_0040, 32'h0});
    c("discard_ack",     0, 1, 1, 32'hDEAD_BEEF, R0, 1, 32'h8000_000C, {32'h8000_0040, 32'h0});
    c("branch_fetch",    0, 1, 1, 32'h1111_0000, R0, 1, 32'h8000_0040, {32'h8000_0040, 32'h0});
    c("j_with_ack",      0, 1, 1, 32'h2222_0000, RJ, 1, 32'h8000_0044, {32'h8000_0044, 32'h1111_0000});
    c("jr_no_ack",       0, 1, 0, 32'h0,         RJR, 1, 32'h0000_0100, {32'h0000_0100, 32'h0});
    c("redirect_in_dis", 0, 1, 0, 32'h0,         RJ, 1, 32'h0000_0100, {32'h0000_0200, 32'h0});
    c("dis_ack",         0, 1, 1, 32'hBAD0_0000, R0, 1, 32'h0000_0100, {32'h0000_0100, 32'h0});
    c("j_fetch",         0, 1, 1, 32'h3333_0000, R0, 1, 32'h0000_0100, {32'h0000_0100, 32'h0});
    c("exc_irq_j",       0, 1, 0, 32'h0,         REXC | RIRQ | RJ, 1, 32'h0000_0104, {32'h0000_0104, 32'h3333_0000});
    c("exc_dis_ack",     0, 1, 1, 32'hBAD0_0001, R0, 1, 32'h0000_0104, {32'h8000_0008, 32'h0});
    c("irq_supervisor",  0, 1, 1, 32'h4444_0000, RIRQ, 1, 32'h8000_0008, {32'h8000_0008, 32'h0});
    c("j_stalled",       0, 0, 0, 32'h0,         RJ, 1, 32'h8000_000C, {32'h8000_000C, 32'h4444_0000});
    c("after_stall",     0, 1, 0, 32'h0,         R0, 1, 32'h8000_000C, {32'h8000_000C, 32'h4444_0000});
    c("stall_ack",       0, 0, 1, 32'h6666_0000, R0, 1, 32'h8000_000C, {32'h8000_000C, 32'h0});
    c("z_in_hold",       0, 1, 0, 32'h0,         RZ, 0, 32'h8000_000C, {32'h8000_000C, 32'h0});
    c("hold_flushed",    0, 1, 0, 32'h0,         R0, 1, 32'h8000_0040, {32'h8000_0040, 32'h0});
    c("rst_mid_req",     1, 1, 0, 32'h0,         R0, 0, 32'h8000_0000, {32'h8000_0040, 32'h0});
    c("rst_ack_drop",    1, 1, 1, 32'hBAD0_0002, R0, 0, 32'h8000_0000, 64'h0);
    c("rst_release2",    0, 1, 1, 32'h7777_0000, R0, 1, 32'h8000_0000, 64'h0);
    jr_target = 32'hFFFF_FFFF;
    c("jr_unaligned",    0, 1, 0, 32'h0,         RJR, 1, 32'h8000_0004, {32'h8000_0004, 32'h7777_0000});
    c("wrap_dis_ack",    0, 1, 1, 32'hBAD0_0003, R0, 1, 32'h8000_0004, {32'hFFFF_FFFC, 32'h0});
    c("wrap_fetch",      0, 1, 1, 32'h8888_0000, R0, 1, 32'hFFFF_FFFC, {32'hFFFF_FFFC, 32'h0});
    c("irq_user",        0, 1, 0, 32'h0,         RIRQ, 1, 32'h0000_0000, {32'h0000_0000, 32'h8888_0000});
    c("irq_dis_ack",     0, 1, 1, 32'hBAD0_0004, R0, 1, 32'h0000_0000, {32'h8000_0004, 32'h0});
    c("irq_fetch",       0, 1, 0, 32'h0,         R0, 1, 32'h8000_0004, {32'h8000_0004, 32'h0});
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      miss++;
      $display("FAIL drain: %0d vectors left unchecked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port: clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have port: rst  in  1  reset; synchronous and active-high.
REQ-003 SHALL have port: PC_IF_ID_Write  in  1  1: advance PC and IF_ID; 0: stall (hold both).
REQ-004 SHALL have ports: Z, J, JR  in  1 each  taken-branch, jump and jump-register redirects from decode.
REQ-005 SHALL have ports: branch_target, jump_target, jr_target  in  32 each  redirect addresses.
REQ-006 SHALL have ports: exc  in  1  undefined-instruction trap; irq  in  1  external interrupt.
REQ-007 SHALL have ports: imem_req  out  1; imem_addr  out  32; imem_ack  in  1; imem_rdata  in  32 (valid only when imem_ack=1).
REQ-008 SHALL have port: IF_ID  out  64  [63:32] PC+4, [31:0] instruction.

Function
REQ-009 Redirect priority SHALL be exc (0x80000008) > irq (0x80000004) > JR > J > Z > sequential PC+4.
REQ-010 irq SHALL be ignored while PC[31]=1 (supervisor).
REQ-011 While PC_IF_ID_Write=0, all redirect inputs SHALL be ignored; PC and IF_ID SHALL hold.
REQ-012 imem_req/imem_addr SHALL stay stable from assertion until the cycle imem_ack=1; one response per request.
REQ-013 FSM states: FETCH (request outstanding), DISCARD (outstanding response belongs to a dead path), HOLD (word buffered, no request).
REQ-014 FETCH, advance, ack, no redirect: IF_ID <= {PC+4, imem_rdata}; PC <= PC+4; next request to PC+4 issued next cycle.
REQ-015 FETCH, advance, no ack: IF_ID <= {PC, 32'h0} bubble; PC unchanged.
REQ-016 FETCH, stall, ack: word captured into 1-entry buffer; go HOLD; imem_req=0 while in HOLD.
REQ-017 HOLD, advance, no redirect: IF_ID <= {PC+4, buffer}; PC <= PC+4; go FETCH.
REQ-018 Any accepted redirect: IF_ID <= {target, 32'h0} flush bubble; PC <= target; buffer invalidated.
REQ-019 Redirect in FETCH without ack in the same cycle: go DISCARD; response arriving later SHALL be dropped; then request target, go FETCH.
REQ-020 Redirect in the same cycle as ack: fetched word dropped; stay FETCH; request target next cycle, no DISCARD.
REQ-021 Redirect in DISCARD: PC updated to newest target; remain DISCARD until ack.
REQ-022 Redirect in HOLD: buffer dropped; go FETCH for target.
REQ-023 PC+4 SHALL wrap modulo 2^32; PC[1:0] SHALL be forced to 00 on every load.
REQ-024 Fetch latency with single-cycle memory (ack in request cycle) SHALL be one instruction per cycle, no bubbles.

Reset
REQ-025 While rst=1: PC=0x80000000, IF_ID=64'h0, state FETCH, buffer invalid, imem_req=0, imem_addr=0x80000000.
REQ-026 imem_req SHALL assert the first cycle after rst deasserts; reset asserted while a request is outstanding SHALL abandon it, and its ack SHALL be ignored during reset.

Structure
REQ-027 Shared package SHALL hold RESET_VEC, IRQ_VEC, EXC_VEC, NOP (32'h0) and FSM state encoding.
REQ-028 Next-PC priority selection SHALL be a combinational sub-module next_pc_sel; everything else in fetch_unit.

Verification
REQ-029 Reset release, ack every cycle, rdata=0x20080005 at 0x80000000 -> IF_ID={0x80000004,0x20080005} one cycle after ack; imem_addr 0x80000004 next.
REQ-030 Ack delayed 3 cycles -> 3 bubbles {PC,0x0}, imem_addr stable throughout, then correct word.
REQ-031 Stall on ack cycle for 2 cycles -> IF_ID held, imem_req=0, buffered word appears on first advance cycle.
REQ-032 Z=1, branch_target=0x80000040 while request outstanding, ack 2 cycles later with 0xDEADBEEF -> 0xDEADBEEF never reaches IF_ID; next imem_addr=0x80000040.
REQ-033 exc, irq, J asserted together, PC[31]=0 -> PC=0x80000008; irq alone with PC[31]=1 -> sequential PC.
REQ-034 J=1 with PC_IF_ID_Write=0 -> ignored; PC and IF_ID unchanged.
